// File: rtl/pipe_sequencer.sv
// ---------------------------------------------------------------------------
// pipe_sequencer
//   Run/stall/flush/halt controller for a 5-stage MIPS pipeline.
//   It sequences IDLE -> RUN -> HALT and produces the stage enables.
//   In RUN it detects load-use hazards between ID and EX, redirects the PC
//   on taken branches, counts retirements and stall cycles, and watches for a
//   hung pipeline.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               leave IDLE and begin execution
//   id_rs, id_rt        source register fields of the instruction in ID
//   id_uses_rt          ID instruction reads rt
//   ex_valid            EX holds a real instruction
//   ex_mem_read         EX instruction is a load
//   ex_rt               destination register of the load in EX
//   mem_branch_taken    branch resolved taken in MEM this cycle
//   wb_valid            one instruction retires this cycle
//   pc_write            PC load enable
//   if_id_write         IF/ID load enable
//   id_ex_bubble        insert a NOP into ID/EX
//   flush               squash IF/ID, ID/EX and EX/MEM
//   pcsrc               select the branch target into the PC
//   running             sequencer is in RUN
//   done                sticky: halted after INSTR_COUNT retirements
//   error               sticky: halted by the watchdog
//   retired_count       retirements since start (saturating)
//   stall_count         load-use stall cycles since start (saturating)
// ---------------------------------------------------------------------------
module pipe_sequencer #(
  parameter int INSTR_COUNT = 15,
  parameter int WDOG_CYCLES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             wb_valid,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush,
  output logic             pcsrc,
  output logic             running,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W:0]   LIMIT   = (CNT_W + 1)'(INSTR_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic            halt_first;   // high during the first HALT cycle only
  logic [WD_W-1:0] watchdog;

  logic hz;
  logic retire_last;
  logic wdog_expire;

  // Hazard and halt conditions are evaluated every cycle; only RUN uses them.
  always_comb begin
    hz = ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    retire_last = wb_valid && (({1'b0, retired_count} + 1'b1) == LIMIT);
    wdog_expire = !wb_valid && (watchdog == WD_LAST);
  end

  // Stage controls are combinational so a hazard stalls in the same cycle.
  // NOTE: every output gets a default first so no path through the case
  // leaves one unassigned (which would infer a latch).
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    flush        = 1'b0;
    pcsrc        = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_branch_taken) begin
          // The taken branch squashes the dependent instruction anyway, so
          // it overrides the load-use stall.
          pcsrc       = 1'b1;
          flush       = 1'b1;
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end else if (hz) begin
          id_ex_bubble = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      HALT:    flush = halt_first;
      default: ;
    endcase
  end

  assign running = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      halt_first    <= 1'b0;
      watchdog      <= '0;
      retired_count <= '0;
      stall_count   <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            retired_count <= '0;
            stall_count   <= '0;
            watchdog      <= '0;
            if (INSTR_COUNT == 0) begin
              state      <= HALT;
              done       <= 1'b1;
              halt_first <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (wb_valid) begin
            watchdog <= '0;
            if (retired_count != CNT_MAX) retired_count <= retired_count + 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end

          if (hz && !mem_branch_taken && (stall_count != CNT_MAX))
            stall_count <= stall_count + 1'b1;

          // Retirement limit is checked first so it wins over the watchdog.
          if (retire_last) begin
            state      <= HALT;
            done       <= 1'b1;
            halt_first <= 1'b1;
          end else if (wdog_expire) begin
            state      <= HALT;
            error      <= 1'b1;
            halt_first <= 1'b1;
          end
        end

        HALT: halt_first <= 1'b0;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipe_sequencer
//   Self-checking bench for pipe_sequencer: a table of hazard/branch vectors
//   applied in RUN, plus directed sequences for retirement halt, watchdog,
//   done-vs-watchdog, and reset mid-run.
// ---------------------------------------------------------------------------
module tb_pipe_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_valid, ex_mem_read, mem_branch_taken, wb_valid;
  logic        pc_write, if_id_write, id_ex_bubble, flush, pcsrc;
  logic        running, done, error;
  logic [15:0] retired_count, stall_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_sequencer #(
    .INSTR_COUNT(15),
    .WDOG_CYCLES(64),
    .CNT_W      (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .mem_branch_taken(mem_branch_taken),
    .wb_valid        (wb_valid),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .flush           (flush),
    .pcsrc           (pcsrc),
    .running         (running),
    .done            (done),
    .error           (error),
    .retired_count   (retired_count),
    .stall_count     (stall_count)
  );

  typedef struct packed {
    logic       ex_valid;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       branch;
    logic       exp_pc_write;
    logic       exp_if_id_write;
    logic       exp_bubble;
    logic       exp_flush;
    logic       exp_pcsrc;
    logic       exp_stall_inc;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_inputs();
    start = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_valid = 0;
    ex_mem_read = 0; ex_rt = 0; mem_branch_taken = 0; wb_valid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic do_start();
    start = 1;
    step();
    start = 0;
  endtask

  initial begin
    //                  ev mr ex_rt  id_rs  id_rt  ur br  pc if bu fl ps inc
    vecs[0] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 5'd9,  5'd3,  5'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 5'd9,  5'd3,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 5'd9,  5'd9,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // ---- reset state ----
    do_reset();
    check("rst_running",  running, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_if_id",    if_id_write, 0);
    check("rst_bubble",   id_ex_bubble, 0);
    check("rst_flush",    flush, 0);
    check("rst_pcsrc",    pcsrc, 0);
    check("rst_done",     done, 0);
    check("rst_error",    error, 0);
    check("rst_retired",  retired_count, 0);
    check("rst_stalls",   stall_count, 0);

    // ---- hazard / branch table in RUN ----
    do_start();
    check("start_running", running, 1);
    begin
      int exp_stalls = 0;
      for (int i = 0; i < 9; i++) begin
        ex_valid         = vecs[i].ex_valid;
        ex_mem_read      = vecs[i].ex_mem_read;
        ex_rt            = vecs[i].ex_rt;
        id_rs            = vecs[i].id_rs;
        id_rt            = vecs[i].id_rt;
        id_uses_rt       = vecs[i].id_uses_rt;
        mem_branch_taken = vecs[i].branch;
        #1;
        check($sformatf("v%0d_pc_write", i), pc_write,     vecs[i].exp_pc_write);
        check($sformatf("v%0d_if_id", i),    if_id_write,  vecs[i].exp_if_id_write);
        check($sformatf("v%0d_bubble", i),   id_ex_bubble, vecs[i].exp_bubble);
        check($sformatf("v%0d_flush", i),    flush,        vecs[i].exp_flush);
        check($sformatf("v%0d_pcsrc", i),    pcsrc,        vecs[i].exp_pcsrc);
        step();
        if (vecs[i].exp_stall_inc) exp_stalls++;
        check($sformatf("v%0d_stall_count", i), stall_count, exp_stalls);
      end
    end
    clear_inputs();

    // ---- 15 retirements -> done ----
    do_reset();
    do_start();
    wb_valid = 1;
    steps(14);
    check("ret14_count",   retired_count, 14);
    check("ret14_running", running, 1);
    step();
    wb_valid = 0;
    check("ret15_done",     done, 1);
    check("ret15_count",    retired_count, 15);
    check("ret15_running",  running, 0);
    check("ret15_pc_write", pc_write, 0);
    check("ret15_flush",    flush, 1);
    step();
    check("halt2_flush",    flush, 0);
    check("halt2_pc_write", pc_write, 0);
    // HALT ignores start and wb_valid
    start = 1; wb_valid = 1;
    steps(2);
    start = 0; wb_valid = 0;
    check("halt_start_ign", running, 0);
    check("halt_wb_ign",    retired_count, 15);
    check("halt_done_hold", done, 1);

    // ---- watchdog expiry ----
    do_reset();
    do_start();
    steps(63);
    check("wd63_running", running, 1);
    check("wd63_error",   error, 0);
    step();
    check("wd64_running", running, 0);
    check("wd64_error",   error, 1);
    check("wd64_done",    done, 0);
    check("wd64_flush",   flush, 1);

    // ---- wb_valid on the last watchdog cycle rescues it ----
    do_reset();
    do_start();
    steps(63);
    wb_valid = 1;
    step();
    wb_valid = 0;
    check("wdsave_running", running, 1);
    check("wdsave_error",   error, 0);
    check("wdsave_count",   retired_count, 1);
    steps(62);
    check("wdsave_rearm", running, 1);

    // ---- retirement limit on the watchdog's last cycle: done wins ----
    do_reset();
    do_start();
    wb_valid = 1;
    steps(14);
    wb_valid = 0;
    steps(63);
    wb_valid = 1;
    step();
    wb_valid = 0;
    check("both_done",  done, 1);
    check("both_error", error, 0);

    // ---- reset mid-run with retired_count = 7 ----
    do_reset();
    do_start();
    id_rs = 5'd4; ex_rt = 5'd4; ex_valid = 1; ex_mem_read = 1;
    step();
    ex_valid = 0; ex_mem_read = 0;
    wb_valid = 1;
    steps(7);
    wb_valid = 0;
    check("mid_count",  retired_count, 7);
    check("mid_stalls", stall_count, 1);
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_running", running, 0);
    check("mid_rst_count",   retired_count, 0);
    check("mid_rst_stalls",  stall_count, 0);
    check("mid_rst_done",    done, 0);
    check("mid_rst_error",   error, 0);
    check("mid_rst_pc",      pc_write, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
